cache_controller: RTL

- Initiator/master side of the 2-way data cache (19-bit line address, 64-bit line fill, 32-bit hit data, hit/invalidate interface).
- Sits between the MEM stage and the SRAM controller. Probes the cache on loads, fetches a 64-bit line from SRAM on a miss, then fills the cache.
- Implements write-through/no-allocate stores: the matching cache line is invalidated and the word is written to SRAM.
- Drives `ready` low to freeze the pipeline while an SRAM transaction is outstanding.

---
 rtl/cache_controller_pkg.sv | 15 +
 rtl/cache_controller_sat_counter.sv | 29 ++
 rtl/cache_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cache_controller_pkg.sv
// Shared definitions for the data-cache controller,
// the cache arrays and the SRAM controller.
package cache_controller_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_e;

  localparam logic [31:0] BASE_ADDR    = 32'd1024;
  localparam int unsigned LINE_BYTES   = 8;
  localparam int unsigned CACHE_ADDR_W = 19;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter with enable.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !(&cnt_q)) cnt_d = cnt_q + W'(1);
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_controller.sv
// MEM-stage side of the 2-way data cache: zero-wait hits,
// line fill on load miss, write-through no-allocate stores.
module cache_controller #(
  parameter logic [31:0] BASE_ADDR = cache_controller_pkg::BASE_ADDR,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      address,
  input  logic [31:0]      wdata,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic [18:0]      cache_addr,
  output logic             cache_R_EN,
  output logic             cache_W_EN,
  output logic             cache_invalidate,
  output logic [63:0]      cache_data_in,
  input  logic             cache_hit,
  input  logic [31:0]      cache_data_out,
  output logic [31:0]      sram_address,
  output logic [31:0]      sram_wdata,
  output logic             sram_read,
  output logic             sram_write,
  input  logic [63:0]      sram_rdata,
  input  logic             sram_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  import cache_controller_pkg::*;

  localparam int unsigned CW = CACHE_ADDR_W;
  localparam logic [31:0] LINE_MASK = ~(LINE_BYTES - 1);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] wdata_q;
  logic [CW-1:0] eff;
  logic [31:0] line_addr;
  logic        hit_inc;
  logic        miss_inc;
  logic        accept_st;

  // only the low cache-address bits of the offset are ever used
  assign eff        = address[CW-1:0] - BASE_ADDR[CW-1:0];
  assign cache_addr = eff;
  assign line_addr  = address & LINE_MASK;
  assign cache_data_in = sram_rdata;

  // next state and output decode; hit path is combinational
  always_comb begin
    state_d          = state_q;
    ready            = 1'b0;
    rdata            = '0;
    cache_R_EN       = 1'b0;
    cache_W_EN       = 1'b0;
    cache_invalidate = 1'b0;
    sram_address     = '0;
    sram_wdata       = '0;
    sram_read        = 1'b0;
    sram_write       = 1'b0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    accept_st        = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (MEM_W_EN) begin
          accept_st        = 1'b1;
          cache_invalidate = 1'b1;
          sram_write       = 1'b1;
          sram_address     = address;
          sram_wdata       = wdata;
          ready            = 1'b0;
          state_d          = WRITE;
        end else if (MEM_R_EN) begin
          cache_R_EN = 1'b1;
          if (cache_hit) begin
            rdata   = cache_data_out;
            hit_inc = 1'b1;
          end else begin
            ready    = 1'b0;
            miss_inc = 1'b1;
            state_d  = READ_MISS;
          end
        end
      end
      READ_MISS: begin
        sram_read    = 1'b1;
        sram_address = line_addr;
        if (sram_ready) begin
          cache_W_EN = 1'b1;
          rdata      = eff[2] ? sram_rdata[63:32]
                              : sram_rdata[31:0];
          ready      = 1'b1;
          state_d    = IDLE;
        end
      end
      WRITE: begin
        sram_write   = 1'b1;
        sram_address = address;
        sram_wdata   = wdata_q;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and captured store word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_st) wdata_q <= wdata;
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (hit_inc),
    .cnt_o  (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (miss_inc),
    .cnt_o  (miss_count)
  );

endmodule
